mem_stage_ws: RTL and testbench

- Parametrised successor of the 5-stage pipeline's MEM stage. Contains the EX/MEM pipeline register with stall and flush, plus a byte-addressable data memory.
- Supports RV32I sub-word loads and stores: SB/SH/SW and LB/LH/LW/LBU/LHU, with sign or zero extension.
- Supports a configurable number of memory wait states. While waiting, the block asserts busyM so the hazard unit can freeze earlier stages.
- Sits between the EX stage and the WB stage.

---
 rtl/mem_stage_ws.sv | 176 +++++++++++++++++
 tb/tb_mem_stage_ws.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ws.sv
// MEM stage: EX/MEM pipeline register, byte-addressable data memory with RV32I
// sub-word access and wait states. Optional misalignment check: MEM_MISALIGN_CHECK_EN.
module mem_stage_ws #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallM,
  input  logic            flushM,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      funct3E,
  input  logic [4:0]      rdE,
  input  logic [XLEN-1:0] PCplus4E,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [2:0]      funct3M,
  output logic [4:0]      rdM,
  output logic [XLEN-1:0] PCplus4M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            busyM,
  output logic            misalignM
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_CYCLES);

  logic            r_regwrite;
  logic            r_memwrite;
  logic [1:0]      r_resultsrc;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_pcplus4;
  logic [XLEN-1:0] r_aluresult;
  logic [XLEN-1:0] r_writedata;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_access;
  logic            w_busy;
  logic            w_misalign;
  logic            w_commit;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_off;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rword;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_rdata;

  assign w_access = r_memwrite | (r_resultsrc == 2'b01);
  assign w_busy   = w_access & (r_cnt != WAIT_C);
  assign w_idx    = r_aluresult[AW+1:2];
  assign w_off    = r_aluresult[1:0];

  // EX/MEM register and wait-state counter; busy holds the register like a stall
  always_ff @(posedge clk) begin
    if (reset | flushM) begin
      r_regwrite  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_resultsrc <= '0;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_pcplus4   <= '0;
      r_aluresult <= '0;
      r_writedata <= '0;
      r_cnt       <= '0;
    end else if (stallM | w_busy) begin
      if (w_busy) r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_regwrite  <= RegWriteE;
      r_memwrite  <= MemWriteE;
      r_resultsrc <= ResultSrcE;
      r_funct3    <= funct3E;
      r_rd        <= rdE;
      r_pcplus4   <= PCplus4E;
      r_aluresult <= ALUResultE;
      r_writedata <= SrcBE;
      r_cnt       <= '0;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    if (w_access) begin
      case (r_funct3)
        3'b001, 3'b101: w_misalign = w_off[0];
        3'b010:         w_misalign = |w_off;
        default:        w_misalign = 1'b0;
      endcase
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Store lane enables and data replicated across the word
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_writedata[31:0];
    case (r_funct3)
      3'b000: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{r_writedata[7:0]}};
      end
      3'b001: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_writedata[15:0]}};
      end
      3'b010:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Commit only on the final, unstalled cycle of the access
  assign w_commit = w_access & r_memwrite & ~w_busy & ~stallM & ~flushM &
                    ~reset & ~w_misalign;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign w_rword = r_mem[w_idx];
  assign w_half  = w_off[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    case (w_off)
      2'd0:    w_byte = w_rword[7:0];
      2'd1:    w_byte = w_rword[15:8];
      2'd2:    w_byte = w_rword[23:16];
      default: w_byte = w_rword[31:24];
    endcase
  end

  always_comb begin
    w_rdata = '0;
    if ((r_resultsrc == 2'b01) && !w_misalign) begin
      case (r_funct3)
        3'b000:  w_rdata = {{24{w_byte[7]}}, w_byte};
        3'b001:  w_rdata = {{16{w_half[15]}}, w_half};
        3'b010:  w_rdata = w_rword;
        3'b100:  w_rdata = {24'd0, w_byte};
        3'b101:  w_rdata = {16'd0, w_half};
        default: w_rdata = '0;
      endcase
    end
  end

  assign RegWriteM  = r_regwrite;
  assign MemWriteM  = r_memwrite;
  assign ResultSrcM = r_resultsrc;
  assign funct3M    = r_funct3;
  assign rdM        = r_rd;
  assign PCplus4M   = r_pcplus4;
  assign ALUResultM = r_aluresult;
  assign WriteDataM = r_writedata;
  assign ReadDataM  = XLEN'(w_rdata);
  assign busyM      = w_busy;
  assign misalignM  = w_misalign;

endmodule

// File: tb/tb_mem_stage_ws.sv
// Bench for mem_stage_ws: u0 (no wait states, 16-word memory) and u1 (2 wait states).
// Load results go through per-instance scoreboard queues; timing checks are inline.
module tb_mem_stage_ws;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam logic MIS_EXP = 1'b1;
`else
  localparam logic MIS_EXP = 1'b0;
`endif

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] srcb;
  } ex_t;

  logic clk;
  logic rst0, rst1;
  ex_t  ex0, ex1;

  logic        rw0, mw0, busy0, mis0, rw1, mw1, busy1, mis1;
  logic [1:0]  rs0, rs1;
  logic [2:0]  f30, f31;
  logic [4:0]  rd0, rd1;
  logic [31:0] pc0, alu0, wd0, rdat0, pc1, alu1, wd1, rdat1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_ws #(.XLEN(32), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(rst0), .stallM(ex0.stall), .flushM(ex0.flush),
    .RegWriteE(ex0.regwrite), .MemWriteE(ex0.memwrite), .ResultSrcE(ex0.rs),
    .funct3E(ex0.f3), .rdE(ex0.rd), .PCplus4E(ex0.pc), .ALUResultE(ex0.alu),
    .SrcBE(ex0.srcb), .RegWriteM(rw0), .MemWriteM(mw0), .ResultSrcM(rs0),
    .funct3M(f30), .rdM(rd0), .PCplus4M(pc0), .ALUResultM(alu0),
    .WriteDataM(wd0), .ReadDataM(rdat0), .busyM(busy0), .misalignM(mis0));

  mem_stage_ws #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u1 (
    .clk(clk), .reset(rst1), .stallM(ex1.stall), .flushM(ex1.flush),
    .RegWriteE(ex1.regwrite), .MemWriteE(ex1.memwrite), .ResultSrcE(ex1.rs),
    .funct3E(ex1.f3), .rdE(ex1.rd), .PCplus4E(ex1.pc), .ALUResultE(ex1.alu),
    .SrcBE(ex1.srcb), .RegWriteM(rw1), .MemWriteM(mw1), .ResultSrcM(rs1),
    .funct3M(f31), .rdM(rd1), .PCplus4M(pc1), .ALUResultM(alu1),
    .WriteDataM(wd1), .ReadDataM(rdat1), .busyM(busy1), .misalignM(mis1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ex_t mk(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
    ex_t e;
    e          = '0;
    e.memwrite = mw;
    e.rs       = rs;
    e.regwrite = (rs == 2'b01);
    e.f3       = f3;
    e.rd       = 5'd9;
    e.pc       = a + 32'd4;
    e.alu      = a;
    e.srcb     = b;
    return e;
  endfunction

  function automatic ex_t st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return mk(1'b1, 2'b00, f3, a, b);
  endfunction

  function automatic ex_t ld(input logic [2:0] f3, input logic [31:0] a);
    return mk(1'b0, 2'b01, f3, a, 32'd0);
  endfunction

  // Monitor: a load leaving MEM (not busy, not stalled/flushed) presents its data
  always @(negedge clk) begin
    if (!rst0 && rs0 == 2'b01 && !busy0 && !ex0.stall && !ex0.flush) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u0 unexpected load: got %h expected none", rdat0);
      end else chk("u0 load data", rdat0, q0.pop_front());
    end
    if (!rst1 && rs1 == 2'b01 && !busy1 && !ex1.stall && !ex1.flush) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL u1 unexpected load: got %h expected none", rdat1);
      end else chk("u1 load data", rdat1, q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    ex0 = '0; ex1 = '0;
    tick(); tick();
    chk("u0 reset ctrl", 32'({rw0, mw0, rs0, f30, rd0, busy0, mis0}), 32'd0);
    chk("u0 reset data", pc0 | alu0 | wd0 | rdat0, 32'd0);
    chk("u1 reset ctrl", 32'({rw1, mw1, rs1, f31, rd1, busy1, mis1}), 32'd0);
    chk("u1 reset data", pc1 | alu1 | wd1 | rdat1, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // ---------------- u0: no wait states, 16-word memory ----------------
    ex0 = st(3'b010, 32'h10, 32'hDEADBEEF); tick();
    chk("u0 busy on SW", 32'(busy0), 32'd0);
    chk("u0 WriteDataM", wd0, 32'hDEADBEEF);
    chk("u0 ReadDataM non-load", rdat0, 32'd0);
    ex0 = ld(3'b010, 32'h10); q0.push_back(32'hDEADBEEF); tick();
    chk("u0 busy on LW", 32'(busy0), 32'd0);
    ex0 = st(3'b010, 32'h20, 32'h11223344); tick();
    ex0 = st(3'b000, 32'h21, 32'h00000080); tick();
    ex0 = ld(3'b000, 32'h21); q0.push_back(32'hFFFFFF80); tick();
    ex0 = ld(3'b100, 32'h21); q0.push_back(32'h00000080); tick();
    ex0 = ld(3'b010, 32'h20); q0.push_back(32'h11228044); tick();
    ex0 = st(3'b001, 32'h22, 32'h0000BEEF); tick();
    ex0 = ld(3'b001, 32'h22); q0.push_back(32'hFFFFBEEF); tick();
    ex0 = ld(3'b101, 32'h22); q0.push_back(32'h0000BEEF); tick();
    ex0 = ld(3'b001, 32'h20); q0.push_back(32'hFFFF8044); tick();
    ex0 = st(3'b011, 32'h10, 32'h00000000); tick();
    ex0 = ld(3'b010, 32'h10); q0.push_back(32'hDEADBEEF); tick();
    ex0 = ld(3'b110, 32'h10); q0.push_back(32'h00000000); tick();
    ex0 = st(3'b010, 32'h40, 32'hA5A5A5A5); tick();
    ex0 = ld(3'b010, 32'h00); q0.push_back(32'hA5A5A5A5); tick();
    ex0 = ld(3'b010, 32'h10); q0.push_back(32'hDEADBEEF); tick();
    ex0 = st(3'b010, 32'h0C, 32'h00000000); tick();
    ex0 = st(3'b001, 32'h0F, 32'h00007777); tick();
    chk("u0 misalign SH@0F", 32'(mis0), 32'(MIS_EXP));
    ex0 = ld(3'b010, 32'h0C); q0.push_back(MIS_EXP ? 32'h0 : 32'h77770000); tick();
    chk("u0 misalign LW@0C", 32'(mis0), 32'd0);
    ex0 = st(3'b010, 32'h04, 32'h0BADF00D); tick();
    ex0 = ld(3'b010, 32'h04); q0.push_back(32'h0BADF00D); tick();
    chk("u0 misalign LW@04", 32'(mis0), 32'd0);
    ex0 = ld(3'b010, 32'h06); q0.push_back(MIS_EXP ? 32'h0 : 32'h0BADF00D); tick();
    chk("u0 misalign LW@06", 32'(mis0), 32'(MIS_EXP));
    ex0 = '0; tick();

    // ---------------- u1: two wait states ----------------
    ex1 = st(3'b010, 32'h100, 32'h55AA55AA); tick();
    chk("u1 SW busy c0", 32'(busy1), 32'd1);
    ex1 = ld(3'b010, 32'h100); q1.push_back(32'h55AA55AA); tick();
    chk("u1 SW busy c1", 32'(busy1), 32'd1);
    chk("u1 SW held", 32'(mw1), 32'd1);
    tick();
    chk("u1 SW busy c2", 32'(busy1), 32'd0);
    chk("u1 SW still held", 32'(mw1), 32'd1);
    tick();
    chk("u1 LW captured", 32'(rs1), 32'd1);
    ex1 = '0;
    for (int i = 0; i < 3; i++) begin
      chk("u1 LW addr held", alu1, 32'h100);
      chk("u1 LW busy", 32'(busy1), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    chk("u1 next captured", alu1, 32'd0);

    ex1 = st(3'b010, 32'h100, 32'h12345678); tick();
    chk("u1 flush pre busy", 32'(busy1), 32'd1);
    ex1 = '0; ex1.flush = 1'b1; tick();
    chk("u1 flush ctrl", 32'({rw1, mw1, rs1, f31, rd1, busy1, mis1}), 32'd0);
    chk("u1 flush data", pc1 | alu1 | wd1 | rdat1, 32'd0);
    ex1 = st(3'b010, 32'h100, 32'h00000000); tick(); tick(); tick();
    chk("u1 last wait", 32'(busy1), 32'd0);
    ex1 = '0; ex1.flush = 1'b1; tick();
    ex1 = ld(3'b010, 32'h100); q1.push_back(32'h55AA55AA); tick();
    chk("u1 cnt cleared busy c0", 32'(busy1), 32'd1);
    tick();
    chk("u1 cnt cleared busy c1", 32'(busy1), 32'd1);
    tick();
    chk("u1 cnt cleared busy c2", 32'(busy1), 32'd0);
    ex1 = '0; tick();

    ex1 = st(3'b010, 32'h104, 32'hCAFEF00D); tick(); tick(); tick();
    ex1.stall = 1'b1; tick(); tick();
    chk("u1 stall holds SW", 32'(mw1), 32'd1);
    chk("u1 stall busy", 32'(busy1), 32'd0);
    ex1 = ld(3'b010, 32'h104); q1.push_back(32'hCAFEF00D); tick(); tick(); tick();
    ex1 = '0; tick();

    ex1 = ld(3'b010, 32'h104); tick();
    chk("u1 pre-reset busy", 32'(busy1), 32'd1);
    rst1 = 1'b1; ex1 = '0; tick();
    chk("u1 reset mid-wait busy", 32'(busy1), 32'd0);
    chk("u1 reset mid-wait ctrl", 32'({rw1, mw1, rs1, f31, rd1, busy1, mis1}), 32'd0);
    rst1 = 1'b0; tick();

    chk("u0 queue drained", 32'(q0.size()), 32'd0);
    chk("u1 queue drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
